// File: rtl/io_pin_ctrl.sv
// Pad bridge between the Caravel pads and the MCU pins. It provides input synchronisation,
// per-pin debounce, sticky edge capture with an interrupt, and a config bus with read-back.
module io_pin_ctrl #(
    parameter int IO_PINS     = 16,
    parameter int IO_PADS     = 38,
    parameter int FIRST_PAD   = 8,
    parameter int SYNC_STAGES = 2,
    parameter int DEB_W       = 4
) (
    input  logic               clk,
    input  logic               rst_hard_n,
    input  logic [IO_PADS-1:0] io_in,
    output logic [IO_PADS-1:0] io_out,
    output logic [IO_PADS-1:0] io_oeb,
    output logic               rst_soft_n,
    output logic [IO_PINS-1:0] pin_dir,
    output logic [IO_PINS-1:0] pin_data_in,
    input  logic [IO_PINS-1:0] pin_data_out,
    output logic               irq,
    input  logic               cfg_we,
    input  logic [2:0]         cfg_addr,
    input  logic [IO_PINS-1:0] cfg_wdata,
    output logic [IO_PINS-1:0] cfg_rdata
);

    localparam logic [2:0] A_PROG   = 3'd0;
    localparam logic [2:0] A_DIR    = 3'd1;
    localparam logic [2:0] A_DEB_EN = 3'd2;
    localparam logic [2:0] A_DEB_PER = 3'd3;
    localparam logic [2:0] A_RISE   = 3'd4;
    localparam logic [2:0] A_FALL   = 3'd5;
    localparam logic [2:0] A_STATUS = 3'd6;
    localparam logic [2:0] A_DIN    = 3'd7;

    localparam logic [IO_PADS-1:0] WIN_MASK =
        ({IO_PADS{1'b1}} >> (IO_PADS - IO_PINS)) << FIRST_PAD;

    logic               r_programming;
    logic [IO_PINS-1:0] r_dir;
    logic [IO_PINS-1:0] r_deb_en;
    logic [DEB_W-1:0]   r_deb_period;
    logic [IO_PINS-1:0] r_rise_en;
    logic [IO_PINS-1:0] r_fall_en;
    logic [IO_PINS-1:0] r_edge_status;
    logic [IO_PINS-1:0] r_stable;
    logic [IO_PINS-1:0] r_sync [SYNC_STAGES];

    logic [IO_PINS-1:0] w_win_in;
    logic [IO_PINS-1:0] w_s;
    logic [IO_PINS-1:0] w_stable_next;
    logic [IO_PINS-1:0] w_rise;
    logic [IO_PINS-1:0] w_fall;
    logic [IO_PINS-1:0] w_set;
    logic [IO_PINS-1:0] w_clr;
    logic               w_cnt_clr;
    logic               w_unused_pads;

    assign w_win_in      = io_in[FIRST_PAD +: IO_PINS];
    assign w_unused_pads = ^(io_in & ~WIN_MASK);
    assign w_s           = r_sync[SYNC_STAGES-1];

    assign pin_dir     = r_programming ? '0 : r_dir;
    assign pin_data_in = r_stable & ~pin_dir;
    assign irq         = |r_edge_status;
    assign rst_soft_n  = rst_hard_n & ~r_programming;

    // Config registers; edge_status is handled separately because it also has hardware sets.
    always_ff @(posedge clk) begin
        if (!rst_hard_n) begin
            r_programming <= 1'b0;
            r_dir         <= '0;
            r_deb_en      <= '0;
            r_deb_period  <= '0;
            r_rise_en     <= '0;
            r_fall_en     <= '0;
        end else if (cfg_we) begin
            case (cfg_addr)
                A_PROG:    r_programming <= cfg_wdata[0];
                A_DIR:     r_dir         <= cfg_wdata;
                A_DEB_EN:  r_deb_en      <= cfg_wdata;
                A_DEB_PER: r_deb_period  <= cfg_wdata[DEB_W-1:0];
                A_RISE:    r_rise_en     <= cfg_wdata;
                A_FALL:    r_fall_en     <= cfg_wdata;
                default:   ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_hard_n) begin
            for (int k = 0; k < SYNC_STAGES; k++) begin
                r_sync[k] <= '0;
            end
        end else begin
            r_sync[0] <= w_win_in;
            for (int k = 1; k < SYNC_STAGES; k++) begin
                r_sync[k] <= r_sync[k-1];
            end
        end
    end

    // Changing the debounce configuration restarts every in-flight count.
    assign w_cnt_clr = cfg_we && ((cfg_addr == A_DEB_EN) || (cfg_addr == A_DEB_PER));

    genvar gi;
    generate
        for (gi = 0; gi < IO_PINS; gi++) begin : g_deb
            logic [DEB_W-1:0] r_cnt;
            logic [DEB_W-1:0] w_cnt_next;
            logic             w_st_next;

            always_comb begin
                w_st_next  = r_stable[gi];
                w_cnt_next = '0;
                if (!r_deb_en[gi]) begin
                    w_st_next = w_s[gi];
                end else if (w_s[gi] != r_stable[gi]) begin
                    if (r_cnt == r_deb_period) begin
                        w_st_next = w_s[gi];
                    end else begin
                        w_cnt_next = r_cnt + 1'b1;
                    end
                end
                if (w_cnt_clr) begin
                    w_cnt_next = '0;
                end
            end

            assign w_stable_next[gi] = w_st_next;

            always_ff @(posedge clk) begin
                if (!rst_hard_n) begin
                    r_cnt <= '0;
                end else begin
                    r_cnt <= w_cnt_next;
                end
            end
        end
    endgenerate

    assign w_rise = w_stable_next & ~r_stable;
    assign w_fall = ~w_stable_next & r_stable;
    assign w_set  = ((w_rise & r_rise_en) | (w_fall & r_fall_en)) & ~pin_dir
                    & {IO_PINS{~r_programming}};
    assign w_clr  = (cfg_we && (cfg_addr == A_STATUS)) ? cfg_wdata : '0;

    // A hardware set in the same cycle as a W1C clear wins.
    always_ff @(posedge clk) begin
        if (!rst_hard_n) begin
            r_stable      <= '0;
            r_edge_status <= '0;
        end else begin
            r_stable      <= w_stable_next;
            r_edge_status <= (r_edge_status & ~w_clr) | w_set;
        end
    end

    generate
        for (gi = 0; gi < IO_PADS; gi++) begin : g_pad
            if ((gi >= FIRST_PAD) && (gi < FIRST_PAD + IO_PINS)) begin : g_win
                assign io_oeb[gi] = ~pin_dir[gi-FIRST_PAD];
                assign io_out[gi] = pin_dir[gi-FIRST_PAD] & pin_data_out[gi-FIRST_PAD];
            end else begin : g_off
                assign io_oeb[gi] = 1'b1;
                assign io_out[gi] = 1'b0;
            end
        end
    endgenerate

    always_comb begin
        cfg_rdata = '0;
        case (cfg_addr)
            A_PROG:    cfg_rdata[0]       = r_programming;
            A_DIR:     cfg_rdata          = r_dir;
            A_DEB_EN:  cfg_rdata          = r_deb_en;
            A_DEB_PER: cfg_rdata[DEB_W-1:0] = r_deb_period;
            A_RISE:    cfg_rdata          = r_rise_en;
            A_FALL:    cfg_rdata          = r_fall_en;
            A_STATUS:  cfg_rdata          = r_edge_status;
            A_DIN:     cfg_rdata          = pin_data_in;
            default:   cfg_rdata          = '0;
        endcase
    end

endmodule

// File: tb/tb_io_pin_ctrl.sv
// Bench for io_pin_ctrl: directed scenarios plus a randomized run, all checked against
// a cycle-level reference model of the pin rules kept in this file.
module tb_io_pin_ctrl;
    localparam int NPAD = 38;
    localparam int NPIN = 16;
    localparam int FP   = 8;
    localparam int SS   = 2;

    logic            clk = 1'b0;
    logic            rst_hard_n = 1'b0;
    logic [NPAD-1:0] io_in = '0;
    logic [NPAD-1:0] io_out;
    logic [NPAD-1:0] io_oeb;
    logic            rst_soft_n;
    logic [NPIN-1:0] pin_dir;
    logic [NPIN-1:0] pin_data_in;
    logic [NPIN-1:0] pin_data_out = '0;
    logic            irq;
    logic            cfg_we = 1'b0;
    logic [2:0]      cfg_addr = '0;
    logic [NPIN-1:0] cfg_wdata = '0;
    logic [NPIN-1:0] cfg_rdata;

    int checks = 0;
    int errors = 0;

    io_pin_ctrl dut (
        .clk(clk), .rst_hard_n(rst_hard_n), .io_in(io_in), .io_out(io_out),
        .io_oeb(io_oeb), .rst_soft_n(rst_soft_n), .pin_dir(pin_dir),
        .pin_data_in(pin_data_in), .pin_data_out(pin_data_out), .irq(irq),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata), .cfg_rdata(cfg_rdata)
    );

    always #10 clk = ~clk;

    // Reference model state
    logic            m_prog = 1'b0;
    logic [NPIN-1:0] m_dir = '0, m_deb_en = '0, m_rise_en = '0, m_fall_en = '0;
    logic [NPIN-1:0] m_status = '0, m_stable = '0;
    int              m_per = 0;
    int              m_cnt [NPIN];
    logic [NPIN-1:0] m_hist [$];

    function automatic logic [NPIN-1:0] exp_dir();
        return m_prog ? '0 : m_dir;
    endfunction

    function automatic logic [NPIN-1:0] exp_din();
        return m_stable & ~exp_dir();
    endfunction

    function automatic logic [NPAD-1:0] exp_oeb();
        logic [NPAD-1:0] r = '1;
        logic [NPIN-1:0] d = exp_dir();
        for (int i = 0; i < NPIN; i++) r[FP+i] = ~d[i];
        return r;
    endfunction

    function automatic logic [NPAD-1:0] exp_out();
        logic [NPAD-1:0] r = '0;
        logic [NPIN-1:0] d = exp_dir();
        for (int i = 0; i < NPIN; i++) r[FP+i] = d[i] & pin_data_out[i];
        return r;
    endfunction

    function automatic logic [NPIN-1:0] exp_rdata(input logic [2:0] a);
        case (a)
            3'd0: return {15'b0, m_prog};
            3'd1: return m_dir;
            3'd2: return m_deb_en;
            3'd3: return NPIN'(m_per);
            3'd4: return m_rise_en;
            3'd5: return m_fall_en;
            3'd6: return m_status;
            default: return exp_din();
        endcase
    endfunction

    // Advance the model with the inputs present before the edge, then step the clock.
    task automatic tick();
        logic [NPIN-1:0] pad, s, nst, pdir, setv, clr;
        int ncnt [NPIN];
        pad = io_in[FP +: NPIN];
        if (!rst_hard_n) begin
            m_prog = 1'b0; m_dir = '0; m_deb_en = '0; m_rise_en = '0; m_fall_en = '0;
            m_status = '0; m_stable = '0; m_per = 0;
            for (int i = 0; i < NPIN; i++) m_cnt[i] = 0;
            m_hist = {};
            for (int k = 0; k < SS; k++) m_hist.push_back('0);
        end else begin
            pdir = exp_dir();
            s    = m_hist[SS-1];
            nst  = m_stable;
            for (int i = 0; i < NPIN; i++) begin
                ncnt[i] = 0;
                if (!m_deb_en[i]) nst[i] = s[i];
                else if (s[i] != m_stable[i]) begin
                    if (m_cnt[i] >= m_per) nst[i] = s[i];
                    else ncnt[i] = m_cnt[i] + 1;
                end
            end
            if (cfg_we && (cfg_addr == 3'd2 || cfg_addr == 3'd3))
                for (int i = 0; i < NPIN; i++) ncnt[i] = 0;
            setv = m_prog ? '0 :
                   (((nst & ~m_stable & m_rise_en) | (~nst & m_stable & m_fall_en)) & ~pdir);
            clr  = (cfg_we && cfg_addr == 3'd6) ? cfg_wdata : '0;
            m_status = (m_status & ~clr) | setv;
            m_stable = nst;
            for (int i = 0; i < NPIN; i++) m_cnt[i] = ncnt[i];
            m_hist.push_front(pad);
            void'(m_hist.pop_back());
            if (cfg_we) begin
                case (cfg_addr)
                    3'd0: m_prog    = cfg_wdata[0];
                    3'd1: m_dir     = cfg_wdata;
                    3'd2: m_deb_en  = cfg_wdata;
                    3'd3: m_per     = int'(cfg_wdata[3:0]);
                    3'd4: m_rise_en = cfg_wdata;
                    3'd5: m_fall_en = cfg_wdata;
                    default: ;
                endcase
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic cfg_write(input logic [2:0] a, input logic [NPIN-1:0] d);
        cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
        tick();
        cfg_we = 1'b0;
        $display("cfg write addr=%0d data=%h", a, d);
    endtask

    task automatic test_reset();
        rst_hard_n = 1'b0;
        repeat (3) tick();
        checks++; if (io_oeb !== {NPAD{1'b1}}) begin errors++; $display("FAIL reset_oeb got %h exp all ones", io_oeb); end
        checks++; if (io_out !== '0) begin errors++; $display("FAIL reset_out got %h exp 0", io_out); end
        checks++; if (rst_soft_n !== 1'b0) begin errors++; $display("FAIL reset_soft_n got %b exp 0", rst_soft_n); end
        checks++; if (irq !== 1'b0 || pin_dir !== '0 || pin_data_in !== '0) begin
            errors++; $display("FAIL reset_pins irq=%b dir=%h din=%h exp 0", irq, pin_dir, pin_data_in); end
        rst_hard_n = 1'b1;
        tick();
        $display("test_reset done");
    endtask

    task automatic test_mapping();
        pin_data_out = 16'hFFFF;
        cfg_write(3'd1, 16'h00F0);
        checks++; if (pin_dir !== 16'h00F0) begin errors++; $display("FAIL map_dir got %h exp 00f0", pin_dir); end
        checks++; if (io_oeb !== ({NPAD{1'b1}} & ~(38'hF << 12))) begin
            errors++; $display("FAIL map_oeb got %h exp %h", io_oeb, {NPAD{1'b1}} & ~(38'hF << 12)); end
        checks++; if (io_out !== (38'hF << 12)) begin
            errors++; $display("FAIL map_out got %h exp %h", io_out, 38'hF << 12); end
        checks++; if (rst_soft_n !== 1'b1) begin errors++; $display("FAIL map_soft_n got %b exp 1", rst_soft_n); end
        pin_data_out = '0;
        cfg_write(3'd1, 16'h0000);
    endtask

    task automatic test_sync_latency();
        cfg_write(3'd4, 16'h0001);
        io_in[FP] = 1'b1;
        tick(); tick();
        checks++; if (pin_data_in[0] !== 1'b0) begin errors++; $display("FAIL sync_early got %b exp 0", pin_data_in[0]); end
        tick();
        checks++; if (pin_data_in[0] !== 1'b1) begin errors++; $display("FAIL sync_t3 got %b exp 1", pin_data_in[0]); end
        cfg_addr = 3'd6; #1;
        checks++; if (cfg_rdata !== 16'h0001 || irq !== 1'b1) begin
            errors++; $display("FAIL sync_status got %h irq=%b exp 0001 irq=1", cfg_rdata, irq); end
    endtask

    task automatic test_w1c();
        cfg_write(3'd6, 16'h0001);
        cfg_addr = 3'd6; #1;
        checks++; if (cfg_rdata !== 16'h0000 || irq !== 1'b0) begin
            errors++; $display("FAIL w1c_clear got %h irq=%b exp 0000 irq=0", cfg_rdata, irq); end
        cfg_write(3'd5, 16'h0001);
        io_in[FP] = 1'b0;
        tick(); tick();
        cfg_we = 1'b1; cfg_addr = 3'd6; cfg_wdata = 16'h0001;
        tick();
        cfg_we = 1'b0; #1;
        checks++; if (cfg_rdata !== 16'h0001 || irq !== 1'b1) begin
            errors++; $display("FAIL w1c_collision got %h irq=%b exp 0001 irq=1", cfg_rdata, irq); end
        cfg_write(3'd6, 16'hFFFF);
        cfg_write(3'd4, 16'h0000);
        cfg_write(3'd5, 16'h0000);
    endtask

    task automatic test_debounce();
        cfg_write(3'd2, 16'h0002);
        cfg_write(3'd3, 16'h0004);
        cfg_write(3'd4, 16'h0002);
        io_in[FP+1] = 1'b1;
        repeat (3) tick();
        io_in[FP+1] = 1'b0;
        repeat (8) tick();
        cfg_addr = 3'd6; #1;
        checks++; if (pin_data_in[1] !== 1'b0 || cfg_rdata !== 16'h0000) begin
            errors++; $display("FAIL deb_glitch din=%b status=%h exp 0 0000", pin_data_in[1], cfg_rdata); end
        io_in[FP+1] = 1'b1;
        repeat (6) tick();
        checks++; if (pin_data_in[1] !== 1'b0) begin errors++; $display("FAIL deb_early got %b exp 0", pin_data_in[1]); end
        tick(); #1;
        checks++; if (pin_data_in[1] !== 1'b1 || cfg_rdata !== 16'h0002) begin
            errors++; $display("FAIL deb_settle din=%b status=%h exp 1 0002", pin_data_in[1], cfg_rdata); end
        cfg_write(3'd6, 16'hFFFF);
        cfg_write(3'd4, 16'h0000);
    endtask

    task automatic test_programming();
        cfg_write(3'd1, 16'hFFFF);
        cfg_write(3'd0, 16'h0001);
        checks++; if (rst_soft_n !== 1'b0 || pin_dir !== '0) begin
            errors++; $display("FAIL prog_mode soft_n=%b dir=%h exp 0 0000", rst_soft_n, pin_dir); end
        checks++; if (io_oeb !== {NPAD{1'b1}}) begin errors++; $display("FAIL prog_oeb got %h exp all ones", io_oeb); end
        cfg_write(3'd4, 16'hFFFF);
        cfg_write(3'd5, 16'hFFFF);
        cfg_write(3'd2, 16'h0000);
        io_in[FP +: NPIN] = 16'hFFFF;
        repeat (5) tick();
        cfg_addr = 3'd6; #1;
        checks++; if (cfg_rdata !== 16'h0000 || irq !== 1'b0 || pin_data_in !== 16'hFFFF) begin
            errors++; $display("FAIL prog_frozen status=%h irq=%b din=%h exp 0000 0 ffff", cfg_rdata, irq, pin_data_in); end
        cfg_write(3'd0, 16'h0000);
        checks++; if (pin_dir !== 16'hFFFF || rst_soft_n !== 1'b1) begin
            errors++; $display("FAIL prog_exit dir=%h soft_n=%b exp ffff 1", pin_dir, rst_soft_n); end
        io_in[FP +: NPIN] = 16'h0000;
        repeat (5) tick();
        cfg_addr = 3'd6; #1;
        checks++; if (cfg_rdata !== 16'h0000) begin errors++; $display("FAIL out_no_status got %h exp 0000", cfg_rdata); end
        cfg_write(3'd1, 16'h0000);
        cfg_write(3'd4, 16'h0000);
        cfg_write(3'd5, 16'h0000);
    endtask

    task automatic test_readback();
        logic [NPIN-1:0] v [8];
        v[0] = 16'h0001; v[1] = NPIN'($urandom); v[2] = NPIN'($urandom);
        v[3] = NPIN'($urandom); v[4] = NPIN'($urandom); v[5] = NPIN'($urandom);
        for (int a = 0; a < 6; a++) cfg_write(3'(a), v[a]);
        cfg_write(3'd7, 16'hBEEF);
        v[3] = v[3] & 16'h000F;
        v[6] = 16'h0000;
        v[7] = exp_din();
        for (int a = 0; a < 8; a++) begin
            cfg_addr = 3'(a); #1;
            checks++; if (cfg_rdata !== v[a]) begin
                errors++; $display("FAIL readback addr=%0d got %h exp %h", a, cfg_rdata, v[a]); end
        end
        cfg_write(3'd0, 16'h0000);
    endtask

    task automatic test_random();
        logic [NPIN-1:0] flip;
        logic [2:0] ra;
        for (int c = 0; c < 400; c++) begin
            flip = '0;
            for (int i = 0; i < NPIN; i++) flip[i] = ($urandom_range(0, 7) == 0);
            io_in = io_in ^ ({{(NPAD-NPIN-FP){1'b0}}, flip, {FP{1'b0}}} | NPAD'($urandom_range(0, 255)));
            pin_data_out = NPIN'($urandom);
            rst_hard_n = ($urandom_range(0, 199) != 0);
            cfg_we = ($urandom_range(0, 5) == 0);
            cfg_addr = 3'($urandom_range(0, 7));
            cfg_wdata = NPIN'($urandom);
            if (cfg_addr == 3'd0) cfg_wdata[0] = ($urandom_range(0, 3) == 0);
            tick();
            cfg_we = 1'b0;
            rst_hard_n = 1'b1;
            ra = 3'($urandom_range(0, 7));
            cfg_addr = ra; #1;
            checks++; if (pin_data_in !== exp_din()) begin errors++; $display("FAIL rnd_din cyc=%0d got %h exp %h", c, pin_data_in, exp_din()); end
            checks++; if (pin_dir !== exp_dir()) begin errors++; $display("FAIL rnd_dir cyc=%0d got %h exp %h", c, pin_dir, exp_dir()); end
            checks++; if (irq !== (|m_status)) begin errors++; $display("FAIL rnd_irq cyc=%0d got %b exp %b", c, irq, |m_status); end
            checks++; if (io_oeb !== exp_oeb()) begin errors++; $display("FAIL rnd_oeb cyc=%0d got %h exp %h", c, io_oeb, exp_oeb()); end
            checks++; if (io_out !== exp_out()) begin errors++; $display("FAIL rnd_out cyc=%0d got %h exp %h", c, io_out, exp_out()); end
            checks++; if (rst_soft_n !== ~m_prog) begin errors++; $display("FAIL rnd_soft_n cyc=%0d got %b exp %b", c, rst_soft_n, ~m_prog); end
            checks++; if (cfg_rdata !== exp_rdata(ra)) begin
                errors++; $display("FAIL rnd_rdata cyc=%0d addr=%0d got %h exp %h", c, ra, cfg_rdata, exp_rdata(ra)); end
        end
        $display("test_random done checks=%0d", checks);
    endtask

    task automatic test_mid_reset();
        cfg_write(3'd0, 16'h0000);
        cfg_write(3'd2, 16'hFFFF);
        cfg_write(3'd3, 16'h0007);
        cfg_write(3'd4, 16'hFFFF);
        io_in[FP +: NPIN] = ~io_in[FP +: NPIN];
        repeat (4) tick();
        rst_hard_n = 1'b0;
        tick();
        rst_hard_n = 1'b1;
        for (int a = 0; a < 8; a++) begin
            cfg_addr = 3'(a); #1;
            checks++; if (cfg_rdata !== '0) begin
                errors++; $display("FAIL midrst_reg addr=%0d got %h exp 0000", a, cfg_rdata); end
        end
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL midrst_irq got %b exp 0", irq); end
    endtask

    initial begin
        test_reset();
        test_mapping();
        test_sync_latency();
        test_w1c();
        test_debounce();
        test_programming();
        test_readback();
        test_random();
        test_mid_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
